// File: rtl/alushifter_seq.sv
// Command sequencer around a 4-bit combinational ALU/shifter. Shift ops repeat
// for cmd_cnt+1 passes, and results are chained through an accumulator.

module alushifter (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] m,
  input  logic       cin,
  output logic [3:0] r,
  output logic       of
);
  logic [4:0] sum;

  always_comb begin
    sum = '0;
    r   = a;
    of  = 1'b0;
    case (m)
      4'h0: begin sum = {1'b0, a} + {1'b0, b} + {4'b0, cin}; r = sum[3:0]; of = sum[4]; end
      4'h1: begin sum = {1'b0, a} - {1'b0, b} - {4'b0, cin}; r = sum[3:0]; of = sum[4]; end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a & ~b;
      4'h6: r = ~a;
      4'h7: r = b;
      // Shifts flag the bit that falls off the end; 4'hD flags a sign change
      4'h8: begin r = {a[2:0], 1'b0}; of = a[3]; end
      4'h9: begin r = {a[2:0], 1'b1}; of = a[3]; end
      4'hA: begin r = {1'b0, a[3:1]}; of = a[0]; end
      4'hB: begin r = {1'b1, a[3:1]}; of = a[0]; end
      4'hC: begin r = {a[3], a[3:1]}; of = a[0]; end
      4'hD: begin r = {a[2:0], 1'b0}; of = a[3] ^ a[2]; end
      4'hE: r = {a[2:0], a[3]};
      default: r = {a[0], a[3:1]};
    endcase
  end
endmodule

module alushifter_seq #(
  parameter int         CNT_W    = 2,
  parameter logic [3:0] ACC_INIT = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic             cmd_src,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic             res_of,
  output logic [3:0]       acc,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_n;
  logic [3:0]       op_q, op_b, work_a;
  logic [CNT_W-1:0] passes_left;
  logic             of_acc;
  logic [3:0]       alu_r;
  logic             alu_of;

  alushifter u_alu (
    .a  (work_a),
    .b  (op_b),
    .m  (op_q),
    .cin(1'b0),
    .r  (alu_r),
    .of (alu_of)
  );

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_valid) state_n = EXEC;
      EXEC:    if (passes_left == '0) state_n = DONE;
      DONE:    if (res_valid && res_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Working registers carry no reset: they are always reloaded on accept
  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_valid) begin
      op_q        <= cmd_op;
      op_b        <= cmd_b;
      work_a      <= cmd_src ? acc : cmd_a;
      passes_left <= cmd_op[3] ? cmd_cnt : '0;
      of_acc      <= 1'b0;
    end else if (state == EXEC) begin
      work_a <= alu_r;
      of_acc <= of_acc | alu_of;
      if (passes_left != '0) passes_left <= passes_left - 1'b1;
    end
  end

  // The result is registered on the first DONE cycle, then held until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= 4'b0000;
      res_of    <= 1'b0;
      acc       <= ACC_INIT;
    end else if (state == DONE) begin
      if (!res_valid) begin
        res_valid <= 1'b1;
        res_data  <= work_a;
        res_of    <= of_acc;
      end else if (res_ready) begin
        res_valid <= 1'b0;
        acc       <= res_data;
      end
    end
  end
endmodule

// File: tb/tb_alushifter_seq.sv
// Bench for alushifter_seq: directed vector table, back-pressure and reset
// sequences, and random commands checked against an arithmetic reference model.

module tb_alushifter_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = '0, cmd_a = '0, cmd_b = '0;
  logic       cmd_src = 1'b0;
  logic [1:0] cmd_cnt = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic       res_of;
  logic [3:0] acc;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alushifter_seq #(.CNT_W(2), .ACC_INIT(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_src(cmd_src),
    .cmd_cnt(cmd_cnt), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_of(res_of), .acc(acc), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Single pass of the datapath, returns {of, r}, from the op semantics
  function automatic logic [4:0] model_pass(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int ai, bi, s, r, o, sa;
    ai = a; bi = b; r = ai; o = 0;
    case (op)
      4'h0: begin s = ai + bi; r = s % 16; o = (s > 15); end
      4'h1: begin s = ai - bi; r = (s + 16) % 16; o = (s < 0); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a & ~b;
      4'h6: r = 15 - ai;
      4'h7: r = bi;
      4'h8: begin r = (ai * 2) % 16; o = (ai >= 8); end
      4'h9: begin r = (ai * 2 + 1) % 16; o = (ai >= 8); end
      4'hA: begin r = ai / 2; o = ai % 2; end
      4'hB: begin r = ai / 2 + 8; o = ai % 2; end
      4'hC: begin r = ai / 2 + ((ai >= 8) ? 8 : 0); o = ai % 2; end
      4'hD: begin
        sa = (ai >= 8) ? ai - 16 : ai;
        r = (ai * 2) % 16; o = (sa * 2 > 7 || sa * 2 < -8);
      end
      4'hE: r = (ai * 2) % 16 + ai / 8;
      default: r = ai / 2 + (ai % 2) * 8;
    endcase
    return {o[0], r[3:0]};
  endfunction

  // Issue one command, measure latency, handshake the result after rdly cycles
  task automatic run_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic src, input logic [1:0] cnt, input int rdly,
                         output logic [3:0] d, output logic o, output int lat);
    int guard;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_src = src; cmd_cnt = cnt;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!res_valid) chk("res_valid_timeout", 0, 1);
    d = res_data; o = res_of;
    repeat (rdly) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
  endtask

  typedef struct {
    logic [3:0] op, a, b;
    logic       src;
    logic [1:0] cnt;
    logic [3:0] exp_data;
    logic       exp_of;
    int         exp_lat;
    logic [3:0] exp_acc;
  } vec_t;

  vec_t vecs[6];
  logic [3:0] d, model_acc, ra, rb, rop, m_r;
  logic       o, rsrc, m_of;
  logic [1:0] rcnt;
  logic [4:0] pr;
  int lat, passes, guard;
  logic [3:0] held_d;
  logic       held_o;

  initial begin
    vecs[0] = '{4'h0, 4'hF, 4'h1, 1'b0, 2'd0, 4'h0, 1'b1, 2, 4'h0};
    vecs[1] = '{4'h1, 4'hA, 4'h5, 1'b0, 2'd0, 4'h5, 1'b0, 2, 4'h5};
    vecs[2] = '{4'h8, 4'h0, 4'h0, 1'b1, 2'd1, 4'h4, 1'b1, 3, 4'h4};
    vecs[3] = '{4'hE, 4'h9, 4'h0, 1'b0, 2'd0, 4'h3, 1'b0, 2, 4'h3};
    vecs[4] = '{4'hF, 4'h9, 4'h0, 1'b0, 2'd2, 4'h3, 1'b0, 4, 4'h3};
    vecs[5] = '{4'h2, 4'h7, 4'hC, 1'b0, 2'd3, 4'h4, 1'b0, 2, 4'h4};

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc", acc, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].src, vecs[i].cnt, i % 2, d, o, lat);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d_of", i), o, vecs[i].exp_of);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_acc", i), acc, vecs[i].exp_acc);
    end

    // Back-pressure: result held 5 cycles while another command waits
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 4'h3; cmd_b = 4'h4; cmd_src = 1'b0; cmd_cnt = 2'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 4'h3; cmd_a = 4'h8; cmd_b = 4'h1;
    guard = 0;
    while (!res_valid && guard < 20) begin @(negedge clk); guard++; end
    chk("bp_valid", res_valid, 1);
    held_d = res_data; held_o = res_of;
    chk("bp_data", held_d, 7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_data", res_data, held_d);
      chk("bp_hold_of", res_of, held_o);
      chk("bp_cmd_ready", cmd_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_acc", acc, 7);
    chk("bp_pending_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_pending_taken", busy, 1);
    guard = 0;
    while (!res_valid && guard < 20) begin @(negedge clk); guard++; end
    chk("bp_second_data", res_data, 4'h9);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_second_acc", acc, 4'h9);

    // Random commands against the model, chaining through the model accumulator
    model_acc = 4'h9;
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15)); ra = 4'($urandom); rb = 4'($urandom);
      rsrc = 1'($urandom); rcnt = 2'($urandom);
      m_r = rsrc ? model_acc : ra; m_of = 1'b0;
      passes = rop[3] ? rcnt + 1 : 1;
      for (int p = 0; p < passes; p++) begin
        pr = model_pass(rop, m_r, rb);
        m_r = pr[3:0]; m_of = m_of | pr[4];
      end
      run_cmd(rop, ra, rb, rsrc, rcnt, $urandom_range(0, 2), d, o, lat);
      model_acc = m_r;
      chk($sformatf("rnd%0d_op%0h_data", n, rop), d, m_r);
      chk($sformatf("rnd%0d_op%0h_of", n, rop), o, m_of);
      chk($sformatf("rnd%0d_lat", n), lat, passes + 1);
      chk($sformatf("rnd%0d_acc", n), acc, model_acc);
    end

    // Reset in the middle of a 4-pass shift aborts it
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'hA; cmd_a = 4'hF; cmd_b = 4'h0; cmd_src = 1'b0; cmd_cnt = 2'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_data", res_data, 0);
    chk("arst_res_of", res_of, 0);
    chk("arst_acc", acc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", res_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
